// File: rtl/traffic_density_classifier.sv
`default_nettype none
// ============================================================================
// Module   : traffic_density_classifier
// Purpose  : Counts vehicles per fixed window, classes traffic LOW/NORMAL/HIGH
//            and applies the class to the phase timers only at phase boundaries.
//            Hysteresis is compiled in with macro TRAFFIC_DENSITY_HYST_EN.
// Revision : 1.0
// ============================================================================
module traffic_density_classifier #(
    parameter int unsigned WINDOW_TICKS = 500_000_000,
    parameter int unsigned COUNT_W      = 8,
    parameter int unsigned LOW_MAX      = 3,
    parameter int unsigned HIGH_MIN     = 10,
    parameter int unsigned HYST         = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               car_pulse,
    input  logic               phase_boundary,
    output logic               low_mode,
    output logic               high_mode,
    output logic [COUNT_W-1:0] car_count,
    output logic               mode_change
);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_LOW    = 2'd1,
        ST_HIGH   = 2'd2
    } state_t;

    localparam logic [31:0]        c_win_last  = 32'(WINDOW_TICKS - 1);
    localparam logic [COUNT_W-1:0] c_count_max = '1;
    localparam logic [31:0]        c_low_max   = 32'(LOW_MAX);
    localparam logic [31:0]        c_high_min  = 32'(HIGH_MIN);
`ifdef TRAFFIC_DENSITY_HYST_EN
    localparam logic [31:0]        c_low_keep  = 32'(LOW_MAX + HYST);
    localparam logic [31:0]        c_high_keep = 32'(HIGH_MIN - HYST);

    if (LOW_MAX + 2 * HYST >= HIGH_MIN) begin : g_hyst_band_check
        $error("traffic_density_classifier: LOW_MAX+HYST must be below HIGH_MIN-HYST");
    end
`else
    // Without hysteresis the keep-bands collapse onto the plain thresholds.
    localparam logic [31:0]        c_low_keep  = 32'(LOW_MAX + HYST * 0);
    localparam logic [31:0]        c_high_keep = 32'(HIGH_MIN);
`endif

    logic [31:0]        r_win;
    logic [COUNT_W-1:0] r_acc;
    state_t             r_state;
    state_t             r_pend;
    logic               r_pend_vld;

    logic               w_win_end;
    logic [COUNT_W-1:0] w_acc_next;
    logic [31:0]        w_close;
    state_t             w_prop;

    assign w_win_end  = (r_win == c_win_last);
    assign w_acc_next = (car_pulse && (r_acc != c_count_max)) ? r_acc + COUNT_W'(1) : r_acc;
    assign w_close    = 32'(w_acc_next);

    // Proposal is judged against the class active when the window closes.
    always_comb begin
        w_prop = ST_NORMAL;
        if ((r_state == ST_LOW) && (w_close <= c_low_keep)) begin
            w_prop = ST_LOW;
        end else if ((r_state == ST_HIGH) && (w_close >= c_high_keep)) begin
            w_prop = ST_HIGH;
        end else if (w_close <= c_low_max) begin
            w_prop = ST_LOW;
        end else if (w_close >= c_high_min) begin
            w_prop = ST_HIGH;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win       <= '0;
            r_acc       <= '0;
            r_state     <= ST_NORMAL;
            r_pend      <= ST_NORMAL;
            r_pend_vld  <= 1'b0;
            low_mode    <= 1'b0;
            high_mode   <= 1'b0;
            car_count   <= '0;
            mode_change <= 1'b0;
        end else begin
            r_win       <= w_win_end ? '0 : r_win + 32'd1;
            mode_change <= 1'b0;

            if (w_win_end) begin
                car_count  <= w_acc_next;
                r_acc      <= '0;
                r_pend     <= w_prop;
                r_pend_vld <= 1'b1;
            end else begin
                r_acc <= w_acc_next;
            end

            // A coincident window end re-arms pending with the new proposal.
            if (phase_boundary && r_pend_vld) begin
                r_state     <= r_pend;
                low_mode    <= (r_pend == ST_LOW);
                high_mode   <= (r_pend == ST_HIGH);
                mode_change <= (r_pend != r_state);
                if (!w_win_end) begin
                    r_pend_vld <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_density_classifier.sv
`default_nettype none
// Bench for traffic_density_classifier: directed window scenarios plus random
// traffic, checked every cycle against a window/class model.
module tb_traffic_density_classifier;

    localparam int WIN      = 100;
    localparam int LONG_WIN = 320;
    localparam int LOW_MAX  = 3;
    localparam int HIGH_MIN = 10;
    localparam int HYST     = 2;
    localparam int CNT_MAX  = 255;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       car_pulse = 1'b0;
    logic       phase_boundary = 1'b0;
    logic       low_mode, high_mode, mode_change;
    logic [7:0] car_count;
    logic       low_l, high_l, mc_l;
    logic [7:0] count_l;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Model state: m_cls 0=NORMAL 1=LOW 2=HIGH; m_tick is the tick of the next edge.
    int m_tick, m_acc, m_count, m_cls, m_pend;
    bit m_pend_v, m_mc;

    // Snapshots taken inside run_window.
    logic s_low, s_high, s_mc, s_mc_next;
    int   mc_seen;
    bit   high_seen;

    always #5 clk = ~clk;

    traffic_density_classifier #(
        .WINDOW_TICKS(WIN), .COUNT_W(8), .LOW_MAX(LOW_MAX), .HIGH_MIN(HIGH_MIN), .HYST(HYST)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .car_pulse(car_pulse), .phase_boundary(phase_boundary),
        .low_mode(low_mode), .high_mode(high_mode), .car_count(car_count), .mode_change(mode_change)
    );

    traffic_density_classifier #(
        .WINDOW_TICKS(LONG_WIN), .COUNT_W(8), .LOW_MAX(LOW_MAX), .HIGH_MIN(HIGH_MIN), .HYST(HYST)
    ) u_dut_long (
        .clk(clk), .reset_n(reset_n), .car_pulse(car_pulse), .phase_boundary(phase_boundary),
        .low_mode(low_l), .high_mode(high_l), .car_count(count_l), .mode_change(mc_l)
    );

    function automatic int classify(input int cnt, input int cur);
`ifdef TRAFFIC_DENSITY_HYST_EN
        if (cur == 1 && cnt <= LOW_MAX + HYST) return 1;
        if (cur == 2 && cnt >= HIGH_MIN - HYST) return 2;
`endif
        if (cnt <= LOW_MAX) return 1;
        if (cnt >= HIGH_MIN) return 2;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_tick = 0; m_acc = 0; m_count = 0; m_cls = 0; m_pend = 0; m_pend_v = 0; m_mc = 0;
    endtask

    task automatic model_step();
        int old_cls;
        int closing;
        old_cls = m_cls;
        m_mc = 0;
        if (phase_boundary && m_pend_v) begin
            m_mc     = (m_pend != old_cls);
            m_cls    = m_pend;
            m_pend_v = 0;
        end
        if (m_tick == WIN - 1) begin
            closing  = m_acc + int'(car_pulse);
            m_count  = (closing > CNT_MAX) ? CNT_MAX : closing;
            m_pend   = classify(m_count, old_cls);
            m_pend_v = 1;
            m_acc    = 0;
            m_tick   = 0;
        end else begin
            m_acc  = m_acc + int'(car_pulse);
            m_tick = m_tick + 1;
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_clear();
            else model_step();
        end
    end

    // Per-cycle compare against the model.
    initial begin
        logic [7:0] exp_cnt;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                exp_cnt = m_count[7:0];
                chk("cycle_outputs",
                    32'({low_mode, high_mode, mode_change, car_count}),
                    32'({m_cls == 1, m_cls == 2, m_mc, exp_cnt}));
            end
        end
    end

    task automatic tick(input logic cp, input logic pb);
        car_pulse      = cp;
        phase_boundary = pb;
        @(negedge clk);
    endtask

    task automatic run_window(input int npulse, input int pb_t, input bit cp_end);
        if (m_tick != 0) chk("window_alignment", 32'(m_tick), 32'd0);
        for (int t = 0; t < WIN; t++) begin
            tick(((t >= 40) && (t < 40 + npulse)) || (cp_end && (t == WIN - 1)), t == pb_t);
            mc_seen   += int'(mode_change);
            high_seen |= high_mode;
            if (t == pb_t) begin
                s_low = low_mode; s_high = high_mode; s_mc = mode_change;
            end
            if (t == pb_t + 1) s_mc_next = mode_change;
        end
        car_pulse = 1'b0; phase_boundary = 1'b0;
    endtask

    task automatic do_reset();
        car_pulse = 1'b0; phase_boundary = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int rate;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // Build up visible state, then reset mid-window.
        run_window(12, -1, 0);
        chk("first_window_count", 32'(car_count), 32'd12);
        for (int t = 0; t < 50; t++) tick(t % 2 == 1, t == 10);
        chk("pre_reset_high", 32'(high_mode), 32'd1);
        car_pulse = 1'b0; phase_boundary = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk("reset_immediate", 32'({low_mode, high_mode, mode_change, car_count}), 32'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        run_window(4, -1, 0);
        chk("partial_count_lost", 32'(car_count), 32'd4);

        // 300 cycles of heavy traffic without a boundary.
        mc_seen = 0; high_seen = 1'b0;
        repeat (3) run_window(12, -1, 0);
        chk("no_boundary_mc", 32'(mc_seen), 32'd0);
        chk("no_boundary_high", 32'(high_seen), 32'd0);
        chk("count_12", 32'(car_count), 32'd12);

        // Boundary 20 cycles after the window end applies HIGH.
        run_window(8, 19, 0);
        chk("boundary_high", 32'({s_low, s_high, s_mc}), 32'b011);
        chk("mc_single_cycle", 32'(s_mc_next), 32'd0);
        chk("count_8", 32'(car_count), 32'd8);
`ifdef TRAFFIC_DENSITY_HYST_EN
        run_window(7, 19, 0);
        chk("hyst_8_stays_high", 32'({s_low, s_high, s_mc}), 32'b010);
`else
        run_window(9, 19, 0);
        chk("plain_8_normal", 32'({s_low, s_high, s_mc}), 32'b001);
`endif
        run_window(12, 19, 0);
        chk("to_normal", 32'({s_low, s_high}), 32'b00);

        // Pulse and boundary at window end together.
        run_window(2, WIN - 1, 1);
        chk("end_coincide_apply", 32'({s_low, s_high, s_mc}), 32'b011);
        chk("end_pulse_counted", 32'(car_count), 32'd3);
        run_window(0, 50, 0);
        chk("pending_low_applied", 32'({s_low, s_high, s_mc}), 32'b101);
        chk("end_pulse_not_carried", 32'(car_count), 32'd0);

        // Random traffic.
        do_reset();
        for (int w = 0; w < 30; w++) begin
            case ($urandom_range(0, 4))
                0: rate = 0;
                1: rate = 3;
                2: rate = 8;
                3: rate = 12;
                default: rate = 25;
            endcase
            for (int t = 0; t < WIN; t++)
                tick(int'($urandom_range(0, 99)) < rate, $urandom_range(0, 99) < 3);
        end

        // Saturation on the long-window instance.
        do_reset();
        for (int t = 0; t < 300; t++) tick(1'b1, 1'b0);
        for (int t = 0; t < LONG_WIN - 300; t++) tick(1'b0, 1'b0);
        chk("saturated_count", 32'(count_l), 32'd255);
        tick(1'b0, 1'b1);
        chk("saturated_high", 32'({low_l, high_l, mc_l}), 32'b011);
        tick(1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
